vend_ctrl_fsm: RTL
==================

Name: vend_ctrl_fsm

Overview:
- Sequencing controller for the vending-machine datapath. Drives the datapath's 2-bit command bus (SITEM/SMONEY/CLEAR/START).
- Decides when to clear, run, dispense items or dispense items plus change, from user buttons and datapath status (change, change-solution-ok).
- Adds an inactivity timeout that auto-refunds, a post-dispense lockout, and one-cycle error flags for the front panel.

Parameters:
- CLEAR_CYCLES, 2, cycles CLEAR is held after reset or service request (>=1)
- LOCK_CYCLES, 4, cycles START is held after any dispense before buttons are accepted again (>=1)
- TIMEOUT_CYCLES, 1000, idle cycles with nonzero balance before auto-refund (>=2)
- CNT_W, 16, shared counter width; must hold max(CLEAR_CYCLES, LOCK_CYCLES, TIMEOUT_CYCLES)

Ports:
- in_clka  input  1  single clock; all state updates on posedge
- in_restart  input  1  asynchronous, active-high reset
- in_service  input  1  operator restock request (level)
- in_buy  input  1  dispense selected items and keep balance (one-cycle pulse)
- in_finish  input  1  dispense selected items and return change (one-cycle pulse)
- in_activity  input  1  OR of coin-inserted and item-select strobes
- in_change  input  16 signed  datapath change (inserted minus total price; LSB = $0.125)
- in_sol_ok  input  1  datapath change-solution-ok
- out_cmd  output  2  command to datapath: 00 SITEM, 01 SMONEY, 10 CLEAR, 11 START
- out_state  output  3  encoded state, for display and debug
- out_busy  output  1  high in every state except RUN
- out_err_funds  output  1  one-cycle pulse: buy rejected because in_change < 0
- out_err_change  output  1  one-cycle pulse: buy rejected because !in_sol_ok
- out_timeout  output  1  one-cycle pulse: auto-refund issued

Behaviour:
- All outputs are registered on posedge in_clka. The datapath samples on negedge, giving a half-cycle setup margin.
- Reset: state=CLEAR (out_state 0), out_cmd=10, counter=0, out_busy=1, all pulse outputs 0.
- CLEAR (0), cmd=10: counts CLEAR_CYCLES, then goes to RUN. While in_service is high, the counter is held at 0.
- RUN (1), cmd=11, priority order:
  - in_service: go to CLEAR.
  - in_finish: go to MONEY.
  - in_buy with in_change[15]=1: out_err_funds=1, stay in RUN.
  - in_buy with !in_sol_ok: out_err_change=1, stay in RUN.
  - in_buy otherwise: go to ITEM.
  - Timeout path: counter increments each cycle while in_change != 0 and in_activity=0. It resets on in_activity, on in_change==0, or on any buy/finish pulse. When counter == TIMEOUT_CYCLES-1: out_timeout=1, go to MONEY.
- ITEM (2), cmd=00: exactly one cycle, then LOCK.
- MONEY (3), cmd=01: exactly one cycle, then LOCK. The datapath decides item dispense vs. pure refund.
- LOCK (4), cmd=11: counts LOCK_CYCLES, then RUN. in_buy and in_finish are ignored. in_service goes to CLEAR.
- Counter is zeroed on every state change.
- Error and timeout flags are at most one cycle wide, and only one of them is asserted per cycle.
- Unused encodings 5–7 go to CLEAR on the next cycle.
- in_restart asserted mid-ITEM/MONEY forces out_cmd=10 asynchronously. A partial dispense is acceptable; the datapath reloads on CLEAR.
- Simultaneous in_buy and in_finish: in_finish wins, with no error pulse.

Decomposition:
- Shared package vend_pkg holds:
  - command constants: SITEM_CMD, SMONEY_CMD, CLEAR_CMD, START_CMD
  - state encodings: CLEAR..LOCK
  - money LSB scaling
- The datapath and the testbench import the same package.
- One sub-module, vend_cycle_cnt: a loadable/clearable CNT_W counter with terminal-count compare, reused for the clear, lock and timeout counts.

Test Plan:
- Reset, release, no stimulus -> out_cmd=10 for 2 cycles, then 11; out_busy falls at cycle 3.
- RUN, in_change=16'sd4, in_sol_ok=1, in_buy -> next cycle out_cmd=00 for 1 cycle, 11 for 4 cycles (busy=1), then RUN.
- RUN, in_change=-16'sd6, in_buy -> out_err_funds=1 for 1 cycle, out_cmd stays 11, no ITEM state.
- RUN, in_change=16'sd2, in_sol_ok=0, in_buy -> out_err_change pulse. Same cycle with in_finish=1 -> MONEY (cmd 01), no error.
- TIMEOUT_CYCLES=10, in_change=8, no activity -> out_timeout and transition to MONEY after exactly 10 cycles. An in_activity pulse at cycle 5 restarts the count.
- in_restart asserted during MONEY -> out_cmd=10 immediately, without waiting for a clock edge. in_service held in LOCK -> CLEAR, held until service drops, then 2 more cycles.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending-machine types: datapath commands, controller states
// and money scaling, imported by the controller, datapath and bench.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_RUN   = 3'd1,
    ST_ITEM  = 3'd2,
    ST_MONEY = 3'd3,
    ST_LOCK  = 3'd4
  } vend_state_e;

  localparam logic [1:0] SITEM_CMD  = 2'b00;
  localparam logic [1:0] SMONEY_CMD = 2'b01;
  localparam logic [1:0] CLEAR_CMD  = 2'b10;
  localparam logic [1:0] START_CMD  = 2'b11;

  // Money is fixed point: one LSB is $0.125
  localparam int MONEY_FRAC_BITS = 3;
  localparam int MONEY_LSB_MILLS = 125;

  function automatic logic [1:0] cmd_of(vend_state_e s);
    logic [1:0] c;
    case (s)
      ST_RUN:   c = START_CMD;
      ST_ITEM:  c = SITEM_CMD;
      ST_MONEY: c = SMONEY_CMD;
      ST_LOCK:  c = START_CMD;
      default:  c = CLEAR_CMD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vend_ctrl_fsm_cnt.sv
// Clearable up-counter with terminal-count compare, shared by the
// clear, lockout and inactivity-timeout intervals.
module vend_cycle_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/vend_ctrl_fsm.sv
// Vending-machine sequencing controller: drives the datapath command bus,
// handles buy/finish, inactivity refund, post-dispense lockout and service.
module vend_ctrl_fsm
  import vend_pkg::*;
#(
  parameter int CLEAR_CYCLES   = 2,
  parameter int LOCK_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic               in_clka,
  input  logic               in_restart,
  input  logic               in_service,
  input  logic               in_buy,
  input  logic               in_finish,
  input  logic               in_activity,
  input  logic signed [15:0] in_change,
  input  logic               in_sol_ok,
  output logic [1:0]         out_cmd,
  output logic [2:0]         out_state,
  output logic               out_busy,
  output logic               out_err_funds,
  output logic               out_err_change,
  output logic               out_timeout
);

  vend_state_e state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic        busy_q, busy_d;
  logic        efund_q, efund_d;
  logic        echg_q, echg_d;
  logic        tout_q, tout_d;
  logic        cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0] cnt_term;

  vend_cycle_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk  (in_clka),
    .rst  (in_restart),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .term (cnt_term),
    .tc   (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    efund_d = 1'b0;
    echg_d  = 1'b0;
    tout_d  = 1'b0;
    case (state_q)
      ST_CLEAR: cnt_term = CNT_W'(CLEAR_CYCLES - 1);
      ST_LOCK:  cnt_term = CNT_W'(LOCK_CYCLES - 1);
      default:  cnt_term = CNT_W'(TIMEOUT_CYCLES - 1);
    endcase
    case (state_q)
      ST_CLEAR: begin
        if (in_service)  cnt_clr = 1'b1;
        else if (cnt_tc) state_d = ST_RUN;
        else             cnt_inc = 1'b1;
      end
      ST_RUN: begin
        if (in_service) begin
          state_d = ST_CLEAR;
        end else if (in_finish) begin
          state_d = ST_MONEY;
        end else if (in_buy) begin
          cnt_clr = 1'b1;
          if (in_change[15])   efund_d = 1'b1;
          else if (!in_sol_ok) echg_d  = 1'b1;
          else                 state_d = ST_ITEM;
        end else if (in_activity || in_change == '0) begin
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          tout_d  = 1'b1;
          state_d = ST_MONEY;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_ITEM, ST_MONEY: state_d = ST_LOCK;
      ST_LOCK: begin
        if (in_service)  state_d = ST_CLEAR;
        else if (cnt_tc) state_d = ST_RUN;
        else             cnt_inc = 1'b1;
      end
      default: state_d = ST_CLEAR;
    endcase
    // every interval starts from zero in the state it times
    if (state_d != state_q) cnt_clr = 1'b1;
    cmd_d  = cmd_of(state_d);
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      state_q <= ST_CLEAR;
      cmd_q   <= CLEAR_CMD;
      busy_q  <= 1'b1;
      efund_q <= 1'b0;
      echg_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      efund_q <= efund_d;
      echg_q  <= echg_d;
      tout_q  <= tout_d;
    end
  end

  assign out_cmd        = cmd_q;
  assign out_state      = state_q;
  assign out_busy       = busy_q;
  assign out_err_funds  = efund_q;
  assign out_err_change = echg_q;
  assign out_timeout    = tout_q;

endmodule
